// File: rtl/drop_sched_pkg.sv
// Shared types for the drop scheduler: the FIFO entry layout and the decision encoding.
package drop_sched_pkg;

    localparam int DEFAULT_COUNT_WIDTH = 8;

    typedef enum logic {
        DEC_DROP = 1'b0,
        DEC_FWD  = 1'b1
    } dec_e;

    // Entry at the default width; the top redeclares the same layout at its own COUNT_WIDTH.
    typedef struct packed {
        logic                           fwd;
        logic [DEFAULT_COUNT_WIDTH-1:0] count;
    } entry_t;

    function automatic int entry_width(input int count_width);
        return count_width + 1;
    endfunction

endpackage

// File: rtl/drop_sched_fifo.sv
// Synchronous DEPTH-entry FIFO of {fwd, count} entries with an in-place decrement of the head count.
module drop_sched_fifo
    import drop_sched_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int DEPTH       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [COUNT_WIDTH:0]           push_data,
    input  logic                           pop,
    input  logic                           dec_head,
    output logic [COUNT_WIDTH:0]           head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = entry_width(COUNT_WIDTH);

    typedef logic [AW:0] ptr_t;

    logic [W-1:0] mem [DEPTH];
    ptr_t         wr_ptr;
    ptr_t         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptr_t'(1);
            end
        end
    end

    // Push and head decrement never target the same slot: a decrement needs a
    // non-empty FIFO and a push is refused while full.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
        if (dec_head) begin
            mem[rd_ptr[AW-1:0]] <= {head[COUNT_WIDTH], head[COUNT_WIDTH-1:0] - COUNT_WIDTH'(1)};
        end
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == ptr_t'(DEPTH));

endmodule

// File: rtl/drop_sched.sv
// Drop scheduler: folds filter verdicts into {fwd, count} entries and replays them as per-packet decisions.
// Optional macro DROP_SCHED_EAGER_EN: issue drops for pending rejects while the FIFO is empty.
module drop_sched
    import drop_sched_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   verdict_vld,
    input  logic                   verdict_acc,
    output logic                   verdict_rdy,
    output logic                   dec_vld,
    output logic                   dec_fwd,
    input  logic                   dec_rdy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam logic [COUNT_WIDTH-1:0] RC_MAX = '1;

    typedef struct packed {
        logic                   fwd;
        logic [COUNT_WIDTH-1:0] count;
    } entry_w_t;

    logic [COUNT_WIDTH-1:0] rc;
    logic [COUNT_WIDTH-1:0] rc_base;
    logic [COUNT_WIDTH-1:0] rc_next;
    entry_w_t               head;
    entry_w_t               push_entry;
    logic                   push;
    logic                   pop;
    logic                   dec_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   verdict_fire;
    logic                   dec_fire;
    logic                   eager_vld;
    logic                   eager_drop;
    dec_e                   dec_kind;

    drop_sched_fifo #(
        .COUNT_WIDTH (COUNT_WIDTH),
        .DEPTH       (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .dec_head  (dec_head),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef DROP_SCHED_EAGER_EN
    assign eager_vld = fifo_empty && (rc != '0);
`else
    assign eager_vld = 1'b0;
`endif

    assign verdict_rdy  = !rst && !fifo_full;
    assign verdict_fire = verdict_vld && verdict_rdy;

    assign dec_kind   = (!fifo_empty && (head.count == '0) && head.fwd) ? DEC_FWD : DEC_DROP;
    assign dec_vld    = !fifo_empty || eager_vld;
    assign dec_fwd    = (dec_kind == DEC_FWD);
    assign dec_fire   = dec_vld && dec_rdy;
    assign eager_drop = dec_fire && fifo_empty;

    // An eager drop consumes one pending reject before the incoming verdict is folded in.
    always_comb begin
        rc_base    = rc - COUNT_WIDTH'(eager_drop);
        rc_next    = rc_base;
        push       = 1'b0;
        push_entry = '{fwd: 1'b0, count: rc_base};
        if (verdict_fire) begin
            if (verdict_acc) begin
                push       = 1'b1;
                push_entry = '{fwd: 1'b1, count: rc_base};
                rc_next    = '0;
            end else if (rc_base == RC_MAX) begin
                push       = 1'b1;
                push_entry = '{fwd: 1'b0, count: RC_MAX};
                rc_next    = COUNT_WIDTH'(1);
            end else begin
                rc_next = rc_base + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        pop      = 1'b0;
        dec_head = 1'b0;
        if (dec_fire && !fifo_empty) begin
            if (head.count == '0) begin
                pop = 1'b1;
            end else if ((head.count == COUNT_WIDTH'(1)) && !head.fwd) begin
                pop = 1'b1;
            end else begin
                dec_head = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rc <= '0;
        end else begin
            rc <= rc_next;
        end
    end

endmodule
